shift_register_sequencer: RTL and testbench

Command-driven controller that sits directly upstream of the 4-bit universal shift register and drives its mode selects (s1, s0), parallel input and serial fill inputs.
- Accepts one command per valid/ready handshake: load, shift, rotate, or load-then-shift, with a repeat count.
- Sequences the register for the required number of clocks, then captures the register's parallel output as the result.
- Lets higher-level datapaths issue multi-bit shift operations without hand-timing s1/s0.

---
 rtl/shift_register_sequencer_pkg.sv | 41 ++++
 rtl/shift_register_sequencer_if.sv | 28 ++
 rtl/shift_register_sequencer.sv | 165 ++++++++++++++++
 tb/tb_shift_register_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_register_sequencer_pkg.sv
// Shared types and constants for the shift register sequencer.
//   op_t     : command operation codes (6 and 7 are illegal)
//   state_t  : sequencer FSM states
//   MODE_*   : {s1,s0} encodings understood by the universal shift register
package shift_seq_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_SHR   = 3'd1,
        OP_SHL   = 3'd2,
        OP_ROR   = 3'd3,
        OP_ROL   = 3'd4,
        OP_LDSHR = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    function automatic logic is_legal(input logic [2:0] op);
        return op <= 3'd5;
    endfunction

    function automatic logic is_load(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_LDSHR);
    endfunction

    // Direction of the shifting phase for a legal shift/rotate/LDSHR op.
    function automatic logic [1:0] shift_mode(input logic [2:0] op);
        return ((op == OP_SHL) || (op == OP_ROL)) ? MODE_SHL : MODE_SHR;
    endfunction

endpackage

// File: rtl/shift_register_sequencer_if.sv
// Command handshake bundle for the shift register sequencer.
//   cmd_valid/cmd_ready : one command transferred per edge with both high
//   cmd_op              : operation code (shift_seq_pkg::op_t values)
//   cmd_count           : number of shift/rotate clocks
//   cmd_data            : parallel load value
//   cmd_fill            : serial fill bit for SHR/SHL/LDSHR
// master drives the command, slave (the sequencer) returns cmd_ready.
interface shift_register_sequencer_if #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 3
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [COUNT_W-1:0] cmd_count;
    logic [WIDTH-1:0]   cmd_data;
    logic               cmd_fill;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill,
        output cmd_ready
    );
endinterface

// File: rtl/shift_register_sequencer.sv
// Command-driven controller for a 4-bit universal shift register.
// Accepts load / shift / rotate / load-then-shift commands with a repeat
// count, sequences the register's mode selects for the required number of
// clocks, then captures the register's parallel output as the result.
// Ports:
//   CLK, Clear_b      : clock, asynchronous active-low reset
//   cmd (slave)       : command handshake (valid/ready, op, count, data, fill)
//   A_par             : feedback from the register's parallel output
//   s1, s0            : register mode (00 hold, 01 SHR, 10 SHL, 11 load)
//   I_par             : parallel load value, 0 unless loading
//   MSB_in, LSB_in    : serial inputs for right/left shift, 0 unless used
//   busy              : sequencer not idle
//   done, result, err : one-cycle completion pulse, captured A_par, illegal op
module shift_register_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 3
) (
    input  logic                     CLK,
    input  logic                     Clear_b,
    shift_register_sequencer_if.slave cmd,
    input  logic [WIDTH-1:0]         A_par,
    output logic                     s1,
    output logic                     s0,
    output logic [WIDTH-1:0]         I_par,
    output logic                     MSB_in,
    output logic                     LSB_in,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result,
    output logic                     err
);

    state_t             state;
    logic [2:0]         op_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] cnt_q;
    logic               fill_q;
    logic               illegal_q;

    // Registered Moore outputs, updated on the edge that enters each state.
    logic [1:0]         mode_q;
    logic [WIDTH-1:0]   i_par_q;
    logic               msb_fill_q;
    logic               lsb_fill_q;
    logic               ror_q;
    logic               rol_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               err_q;

    logic accept;
    assign accept = cmd.cmd_valid && ready_q;

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            state      <= IDLE;
            op_q       <= '0;
            count_q    <= '0;
            cnt_q      <= '0;
            fill_q     <= 1'b0;
            illegal_q  <= 1'b0;
            mode_q     <= MODE_HOLD;
            i_par_q    <= '0;
            msb_fill_q <= 1'b0;
            lsb_fill_q <= 1'b0;
            ror_q      <= 1'b0;
            rol_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // ready comes up on the first edge after reset release
                    ready_q <= 1'b1;
                    if (accept) begin
                        op_q      <= cmd.cmd_op;
                        count_q   <= cmd.cmd_count;
                        fill_q    <= cmd.cmd_fill;
                        illegal_q <= !is_legal(cmd.cmd_op);
                        err_q     <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        if (is_load(cmd.cmd_op)) begin
                            state   <= LOAD;
                            mode_q  <= MODE_LOAD;
                            i_par_q <= cmd.cmd_data;
                        end else if (is_legal(cmd.cmd_op) && (cmd.cmd_count != '0)) begin
                            state  <= SHIFT;
                            cnt_q  <= cmd.cmd_count;
                            mode_q <= shift_mode(cmd.cmd_op);
                            msb_fill_q <= (cmd.cmd_op == OP_SHR) ? cmd.cmd_fill : 1'b0;
                            lsb_fill_q <= (cmd.cmd_op == OP_SHL) ? cmd.cmd_fill : 1'b0;
                            ror_q      <= (cmd.cmd_op == OP_ROR);
                            rol_q      <= (cmd.cmd_op == OP_ROL);
                        end else begin
                            // zero count or illegal op: nothing to sequence
                            state <= FIN;
                        end
                    end
                end

                LOAD: begin
                    i_par_q <= '0;
                    if ((op_q == OP_LDSHR) && (count_q != '0)) begin
                        state      <= SHIFT;
                        cnt_q      <= count_q;
                        mode_q     <= MODE_SHR;
                        msb_fill_q <= fill_q;
                    end else begin
                        state  <= FIN;
                        mode_q <= MODE_HOLD;
                    end
                end

                SHIFT: begin
                    // Last shifting cycle when the counter reads 1.
                    if (cnt_q == COUNT_W'(1)) begin
                        state      <= FIN;
                        cnt_q      <= '0;
                        mode_q     <= MODE_HOLD;
                        msb_fill_q <= 1'b0;
                        lsb_fill_q <= 1'b0;
                        ror_q      <= 1'b0;
                        rol_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - COUNT_W'(1);
                    end
                end

                FIN: begin
                    // Register is holding, so A_par is the settled result.
                    state    <= IDLE;
                    result_q <= A_par;
                    err_q    <= illegal_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign s1        = mode_q[1];
    assign s0        = mode_q[0];
    assign I_par     = i_par_q;
    // Rotates feed the bit falling off the far end straight back in.
    assign MSB_in    = ror_q ? A_par[0]       : msb_fill_q;
    assign LSB_in    = rol_q ? A_par[WIDTH-1] : lsb_fill_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign err       = err_q;
    assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_shift_register_sequencer.sv
module tb_shift_register_sequencer;
    localparam int W  = 4;
    localparam int CW = 3;

    logic          CLK;
    logic          Clear_b;
    logic [W-1:0]  A_par;
    logic          s1, s0, MSB_in, LSB_in, busy, done, err;
    logic [W-1:0]  I_par, result;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_reg;

    shift_register_sequencer_if #(.WIDTH(W), .COUNT_W(CW)) ifc ();

    shift_register_sequencer #(.WIDTH(W), .COUNT_W(CW)) dut (
        .CLK(CLK), .Clear_b(Clear_b), .cmd(ifc.slave), .A_par(A_par),
        .s1(s1), .s0(s0), .I_par(I_par), .MSB_in(MSB_in), .LSB_in(LSB_in),
        .busy(busy), .done(done), .result(result), .err(err)
    );

    // Universal shift register downstream of the sequencer.
    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) A_par <= '0;
        else begin
            case ({s1, s0})
                2'b01:   A_par <= {MSB_in, A_par[W-1:1]};
                2'b10:   A_par <= {A_par[W-2:0], LSB_in};
                2'b11:   A_par <= I_par;
                default: A_par <= A_par;
            endcase
        end
    end

    initial begin
        CLK = 1'b0;
        #2;
        forever #5 CLK = ~CLK;
    end

    // Reference: what a command does to a register currently holding cur.
    function automatic void ref_cmd(input logic [2:0] op, input int cnt,
                                    input logic [W-1:0] data, input bit fill,
                                    input logic [W-1:0] cur,
                                    output logic [W-1:0] res, output bit e,
                                    output int lat, output int nld,
                                    output int nr, output int nl);
        int v, k;
        v = int'(cur); e = 0; nld = 0; nr = 0; nl = 0;
        k = cnt % W;
        case (op)
            3'd0: begin v = int'(data); nld = 1; end
            3'd1: begin for (int i = 0; i < cnt; i++) v = (v >> 1) | (int'(fill) << (W-1)); nr = cnt; end
            3'd2: begin for (int i = 0; i < cnt; i++) v = ((v << 1) | int'(fill)) % 16; nl = cnt; end
            3'd3: begin v = ((v >> k) | (v << (W-k))) % 16; nr = cnt; end
            3'd4: begin v = ((v << k) | (v >> (W-k))) % 16; nl = cnt; end
            3'd5: begin
                v = int'(data); nld = 1;
                for (int i = 0; i < cnt; i++) v = (v >> 1) | (int'(fill) << (W-1));
                nr = cnt;
            end
            default: e = 1;
        endcase
        res = W'(v);
        lat = 2 + nld + nr + nl;
    endfunction

    // Drives one command and observes it through to done (no checking here).
    task automatic run_cmd(input bit skip, input logic [2:0] op, input logic [CW-1:0] cnt,
                           input logic [W-1:0] data, input bit fill,
                           output int lat, output int nld, output int nr, output int nl,
                           output logic [W-1:0] res, output logic e, output logic e_c1,
                           output logic [W-1:0] ipar_seen, output int sel_bad,
                           output int wait_cyc, output bit tmo);
        lat = 0; nld = 0; nr = 0; nl = 0; res = 'x; e = 1'bx; e_c1 = 1'bx;
        ipar_seen = '0; sel_bad = 0; wait_cyc = 0; tmo = 0;
        if (!skip) @(negedge CLK);
        ifc.cmd_valid = 1'b1; ifc.cmd_op = op; ifc.cmd_count = cnt;
        ifc.cmd_data = data; ifc.cmd_fill = fill;
        while (ifc.cmd_ready !== 1'b1 && wait_cyc < 20) begin
            @(negedge CLK); wait_cyc++;
        end
        if (ifc.cmd_ready !== 1'b1) begin
            tmo = 1; ifc.cmd_valid = 1'b0; return;
        end
        @(posedge CLK); #1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op = 3'($urandom); ifc.cmd_count = CW'($urandom);
        ifc.cmd_data = W'($urandom); ifc.cmd_fill = 1'($urandom);
        while (lat < 40) begin
            @(negedge CLK); lat++;
            if (lat == 1) e_c1 = err;
            if (done === 1'b1) break;
            case ({s1, s0})
                2'b11: begin nld++; ipar_seen = I_par; end
                2'b01: nr++;
                2'b10: nl++;
                default: ;
            endcase
            if ({s1, s0} != 2'b01 && MSB_in !== 1'b0) sel_bad++;
            if ({s1, s0} != 2'b10 && LSB_in !== 1'b0) sel_bad++;
            if ({s1, s0} != 2'b11 && I_par !== '0) sel_bad++;
            if (busy !== 1'b1 || ifc.cmd_ready !== 1'b0) sel_bad++;
        end
        if (done === 1'b1) begin
            res = result; e = err;
            if (busy !== 1'b0 || ifc.cmd_ready !== 1'b1 || {s1, s0} !== 2'b00) sel_bad++;
        end else tmo = 1;
    endtask

    task automatic test_reset();
        #5 Clear_b = 1'b0;
        #5;
        checks++; if ({s1, s0} !== 2'b00) begin errors++; $display("FAIL reset_mode got %b want 00", {s1, s0}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if ({done, err, MSB_in, LSB_in} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {done, err, MSB_in, LSB_in}); end
        checks++; if (I_par !== '0) begin errors++; $display("FAIL reset_ipar got %h want 0", I_par); end
        checks++; if (ifc.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b want 0", ifc.cmd_ready); end
        #2 Clear_b = 1'b1;
        @(posedge CLK); #1;
        checks++; if (ifc.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", ifc.cmd_ready); end
        exp_reg = '0;
    endtask

    // Runs a command, checks everything against the reference.
    task automatic do_checked(input string name, input bit skip, input logic [2:0] op,
                              input logic [CW-1:0] cnt, input logic [W-1:0] data, input bit fill);
        int lat, nld, nr, nl, sel_bad, wc, x_lat, x_ld, x_r, x_l;
        logic [W-1:0] res, ip, x_res;
        logic e, e1;
        bit tmo, x_e;
        ref_cmd(op, int'(cnt), data, fill, exp_reg, x_res, x_e, x_lat, x_ld, x_r, x_l);
        run_cmd(skip, op, cnt, data, fill, lat, nld, nr, nl, res, e, e1, ip, sel_bad, wc, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL %s timeout got 1 want 0", name); end
        checks++; if (res !== x_res) begin errors++; $display("FAIL %s result got %b want %b", name, res, x_res); end
        checks++; if (e !== x_e) begin errors++; $display("FAIL %s err got %b want %b", name, e, x_e); end
        checks++; if (lat !== x_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, x_lat); end
        checks++; if ({nld, nr, nl} !== {x_ld, x_r, x_l}) begin errors++; $display("FAIL %s mode_cycles got %0d/%0d/%0d want %0d/%0d/%0d", name, nld, nr, nl, x_ld, x_r, x_l); end
        checks++; if (sel_bad !== 0) begin errors++; $display("FAIL %s idle_outputs got %0d bad want 0", name, sel_bad); end
        checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL %s err_clear_on_accept got %b want 0", name, e1); end
        if (x_ld == 1) begin
            checks++; if (ip !== data) begin errors++; $display("FAIL %s ipar got %b want %b", name, ip, data); end
        end
        if (skip) begin
            checks++; if (wc !== 0) begin errors++; $display("FAIL %s accept_in_done_cycle waited %0d want 0", name, wc); end
        end
        exp_reg = x_res;
    endtask

    task automatic test_load();
        do_checked("load_1010", 0, 3'd0, 3'd0, 4'b1010, 1'b0);
    endtask

    task automatic test_ldshr();
        do_checked("ldshr_1010_c2", 0, 3'd5, 3'd2, 4'b1010, 1'b1);
    endtask

    task automatic test_rotate();
        do_checked("rot_load", 0, 3'd0, 3'd0, 4'b1010, 1'b0);
        do_checked("rol_1", 0, 3'd4, 3'd1, 4'b0000, 1'b1);
        do_checked("ror_4_wrap", 0, 3'd3, 3'd4, 4'b1111, 1'b1);
        do_checked("ror_7_wrap", 0, 3'd3, 3'd7, 4'b0000, 1'b0);
        do_checked("shr_7_fill", 0, 3'd1, 3'd7, 4'b0000, 1'b1);
    endtask

    task automatic test_zero_illegal();
        do_checked("shl_c0", 0, 3'd2, 3'd0, 4'b0110, 1'b1);
        do_checked("op7_illegal", 0, 3'd7, 3'd3, 4'b0110, 1'b1);
        do_checked("op6_illegal", 0, 3'd6, 3'd0, 4'b1001, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_checked("b2b_first", 0, 3'd5, 3'd1, 4'b0110, 1'b0);
        do_checked("b2b_second", 1, 3'd2, 3'd2, 4'b0000, 1'b1);
        do_checked("b2b_third", 1, 3'd0, 3'd0, 4'b1001, 1'b0);
    endtask

    task automatic test_reset_mid_shift();
        int cyc, dcount;
        do_checked("mid_load", 0, 3'd0, 3'd0, 4'b1111, 1'b0);
        @(negedge CLK);
        ifc.cmd_valid = 1'b1; ifc.cmd_op = 3'd1; ifc.cmd_count = 3'd5;
        ifc.cmd_data = 4'b0000; ifc.cmd_fill = 1'b0;
        @(posedge CLK); #1 ifc.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge CLK);
        checks++; if ({s1, s0} !== 2'b01) begin errors++; $display("FAIL mid_shift_mode got %b want 01", {s1, s0}); end
        Clear_b = 1'b0;
        #1;
        checks++; if ({s1, s0, busy, done, ifc.cmd_ready} !== 5'b0) begin errors++; $display("FAIL mid_reset_outputs got %b want 00000", {s1, s0, busy, done, ifc.cmd_ready}); end
        @(negedge CLK); Clear_b = 1'b1;
        exp_reg = '0;
        dcount = 0;
        for (cyc = 0; cyc < 8; cyc++) begin
            @(negedge CLK);
            if (done === 1'b1) dcount++;
        end
        checks++; if (dcount !== 0) begin errors++; $display("FAIL mid_reset_no_done got %0d done cycles want 0", dcount); end
        do_checked("after_reset_load", 0, 3'd0, 3'd0, 4'b0011, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_checked($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), CW'($urandom), W'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        Clear_b = 1'b1;
        ifc.cmd_valid = 1'b0; ifc.cmd_op = '0; ifc.cmd_count = '0;
        ifc.cmd_data = '0; ifc.cmd_fill = 1'b0;
        exp_reg = '0;
        test_reset();
        test_load();
        test_ldshr();
        test_rotate();
        test_zero_illegal();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
